chunked_serial_adder: RTL and testbench



---
 rtl/chunked_adder_pkg.sv | 18 +
 rtl/chunk_adder.sv | 19 +
 rtl/chunked_serial_adder.sv | 112 +++++++++++
 tb/tb_chunked_serial_adder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/chunked_adder_pkg.sv
// Shared types and helpers for the chunked serial adder.
package chunked_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of a counter that must hold 0..n-1, never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder with carry in and carry out.
module chunk_adder #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  localparam int unsigned SW = CHUNK + 1;

  logic [CHUNK:0] w_full;

  assign w_full  = {1'b0, a} + {1'b0, b} + SW'(ci);
  assign {co, s} = w_full;

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder: WIDTH-bit A+B+Cin, CHUNK bits per clock, LSB chunk first.
// Optional CHUNKED_SERIAL_ADDER_SUB_EN adds a 'sub' input selecting A-B.
module chunked_serial_adder
  import chunked_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             busy
);

  localparam int unsigned     CYCLES   = WIDTH / CHUNK;
  localparam int unsigned     IDXW     = idx_width(CYCLES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(CYCLES - 1);

  state_t                 r_state;
  logic [WIDTH-1:0]       r_a;
  logic [WIDTH-1:0]       r_b;
  logic                   r_carry;
  logic [IDXW-1:0]        r_idx;

  logic [WIDTH-1:0]       w_b_in;
  logic                   w_c_in;
  logic [CHUNK-1:0]       w_s;
  logic                   w_co;
  logic [WIDTH+CHUNK-1:0] w_sum_cat;

  // Subtraction is A + ~B + 1, so only the latched B and carry change.
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
  assign w_b_in = sub ? ~B : B;
  assign w_c_in = sub ? 1'b1 : Cin;
`else
  assign w_b_in = B;
  assign w_c_in = Cin;
`endif

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a  (r_a[CHUNK-1:0]),
    .b  (r_b[CHUNK-1:0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  // New chunk enters at the top; concatenation keeps CHUNK==WIDTH legal.
  assign w_sum_cat = {w_s, Sum};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_carry   <= 1'b0;
      r_idx     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      Sum       <= '0;
      Carry     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            r_a      <= A;
            r_b      <= w_b_in;
            r_carry  <= w_c_in;
            r_idx    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            r_state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          Sum     <= w_sum_cat[WIDTH+CHUNK-1:CHUNK];
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_carry <= w_co;
          r_idx   <= r_idx + IDXW'(1);
          if (r_idx == LAST_IDX) begin
            Carry     <= w_co;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Bench for chunked_serial_adder: WIDTH=8 with CHUNK=2, plus CHUNK=1 and CHUNK=8 instances.
module tb_chunked_serial_adder;

  typedef struct packed {
    logic [7:0] sum;
    logic       carry;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       carry;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, carry, busy, cin, sub;
  logic [7:0] a, b, sum;
  logic       in_valid1, in_ready1, out_valid1, carry1, busy1;
  logic       in_valid2, in_ready2, out_valid2, carry2, busy2;
  logic [7:0] sum1, sum2;
  logic       out_ready_hi;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  res_t sb_q[$];
  int   in_cyc_q[$];
  int   out_cyc_q[$];
  res_t mon_exp;
  vec_t vecs[8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  chunked_serial_adder #(.WIDTH(8), .CHUNK(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .Cin(cin),
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .Sum(sum), .Carry(carry), .busy(busy)
  );

  chunked_serial_adder #(.WIDTH(8), .CHUNK(1)) u_dut_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .A(a), .B(b), .Cin(cin),
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid1), .out_ready(out_ready_hi), .Sum(sum1), .Carry(carry1), .busy(busy1)
  );

  chunked_serial_adder #(.WIDTH(8), .CHUNK(8)) u_dut_c8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .A(a), .B(b), .Cin(cin),
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid2), .out_ready(out_ready_hi), .Sum(sum2), .Carry(carry2), .busy(busy2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every delivered result must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", 32'(sb_q.size()), 1);
      end else begin
        mon_exp = sb_q.pop_front();
        check("sum", 32'(sum), 32'(mon_exp.sum));
        check("carry", 32'(carry), 32'(mon_exp.carry));
      end
      out_cyc_q.push_back(cyc);
    end
  end

  // Presents operands, waits for the handshake, records the expected result.
  task automatic drive_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                          input logic tsub, input logic keep,
                          input logic [7:0] es, input logic ec);
    int k;
    a = ta; b = tb_; cin = tc; sub = tsub; in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 1);
    end else begin
      sb_q.push_back('{sum: es, carry: ec});
      in_cyc_q.push_back(cyc);
    end
    step();
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (sb_q.size() != 0) check("drain_timeout", 32'(sb_q.size()), 0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, busy_n, rdy_bad, lat1, lat2;
    logic [7:0] s1, s2;
    logic c1, c2;

    vecs[0] = '{8'h3C, 8'h15, 1'b1, 8'h52, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};
    vecs[6] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};
    vecs[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_valid1 = 1'b0; in_valid2 = 1'b0;
    out_ready = 1'b1; out_ready_hi = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_sum", 32'(sum), 0);
    check("rst_carry", 32'(carry), 0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // First op: latency, busy span and in_ready low through RUN/DONE.
    drive_op(8'h3C, 8'h15, 1'b1, 1'b0, 1'b0, 8'h52, 1'b0);
    lat = 0; busy_n = 0; rdy_bad = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) busy_n++;
      if (in_ready) rdy_bad++;
    end while (!out_valid && lat < 20);
    check("latency", 32'(lat), 5);
    check("busy_cycles", 32'(busy_n), 4);
    check("in_ready_low_run_done", 32'(rdy_bad), 0);
    step();

    // Vector table, streamed through the scoreboard.
    for (int i = 0; i < 8; i++)
      drive_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, 1'b0, vecs[i].sum, vecs[i].carry);
    wait_drain();

    // Same wrap case on bit-serial and single-pass instances.
    a = 8'hFF; b = 8'h01; cin = 1'b0; sub = 1'b0;
    in_valid1 = 1'b1; in_valid2 = 1'b1;
    step();
    in_valid1 = 1'b0; in_valid2 = 1'b0;
    lat = 0; lat1 = 0; lat2 = 0; s1 = '0; s2 = '0; c1 = 1'b0; c2 = 1'b0;
    while ((lat1 == 0 || lat2 == 0) && lat < 30) begin
      @(negedge clk);
      lat++;
      if (out_valid1 && lat1 == 0) begin lat1 = lat; s1 = sum1; c1 = carry1; end
      if (out_valid2 && lat2 == 0) begin lat2 = lat; s2 = sum2; c2 = carry2; end
    end
    check("c1_sum", 32'(s1), 0);
    check("c1_carry", 32'(c1), 1);
    check("c1_latency", 32'(lat1), 9);
    check("c8_sum", 32'(s2), 0);
    check("c8_carry", 32'(c2), 1);
    check("c8_latency", 32'(lat2), 2);
    step();

    // Backpressure: result held, new operands ignored until delivery.
    out_ready = 1'b0;
    drive_op(8'hA7, 8'h5C, 1'b0, 1'b0, 1'b0, 8'h03, 1'b1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp_out_valid_seen", 32'(out_valid), 1);
    step();
    a = 8'h11; b = 8'h22; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_sum", 32'(sum), 32'h03);
      check("bp_carry", 32'(carry), 1);
      check("bp_in_ready", 32'(in_ready), 0);
    end
    step();
    out_ready = 1'b1;
    drive_op(8'h11, 8'h22, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0);
    wait_drain();

    // Reset in the middle of RUN discards the operation.
    drive_op(8'h40, 8'h40, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("midrst_in_ready", 32'(in_ready), 1);
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_sum", 32'(sum), 0);
    check("midrst_carry", 32'(carry), 0);
    step(); step();
    @(negedge clk) rst_n = 1'b1;
    step();
    drive_op(8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 8'h03, 1'b0);
    wait_drain();

    // Back-to-back with in_valid held high.
    in_cyc_q.delete();
    out_cyc_q.delete();
    drive_op(8'h10, 8'h20, 1'b0, 1'b0, 1'b1, 8'h30, 1'b0);
    drive_op(8'hF0, 8'h20, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1);
    drive_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0);
    wait_drain();
    repeat (8) @(negedge clk);
    check("b2b_outputs", 32'(out_cyc_q.size()), 3);
    if (in_cyc_q.size() == 3 && out_cyc_q.size() == 3) begin
      check("b2b_in_gap0", 32'(in_cyc_q[1] - in_cyc_q[0]), 6);
      check("b2b_in_gap1", 32'(in_cyc_q[2] - in_cyc_q[1]), 6);
      check("b2b_out_gap0", 32'(out_cyc_q[1] - out_cyc_q[0]), 6);
      check("b2b_out_gap1", 32'(out_cyc_q[2] - out_cyc_q[1]), 6);
    end
    step();

`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
    drive_op(8'h05, 8'h07, 1'b0, 1'b1, 1'b0, 8'hFE, 1'b0);
    drive_op(8'h07, 8'h05, 1'b0, 1'b1, 1'b0, 8'h02, 1'b1);
    drive_op(8'h07, 8'h05, 1'b1, 1'b0, 1'b0, 8'h0D, 1'b0);
    wait_drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
